cpu_bus_master: RTL and testbench



---
 rtl/cpu_bus_master.sv | 160 ++++++++++++++++
 tb/tb_cpu_bus_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_master
// Description : Console-side Famicom CPU bus cycle generator. Turns a
//               valid/ready request stream into M2-timed bus cycles toward
//               the cartridge and returns read data. M2 runs continuously;
//               cycles without a request are dummy reads of IDLE_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_master #(
    parameter int          M2_LOW_TICKS  = 3,
    parameter int          M2_HIGH_TICKS = 3,
    parameter logic [15:0] IDLE_ADDR     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in
);

    // Phase encoding; ST_RST is only occupied between reset release and the
    // first clock edge, which launches the first (idle) cycle.
    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    // Counter reload values: the counter counts down to zero on each phase.
    localparam logic [3:0] LOW_LAST  = 4'(M2_LOW_TICKS - 1);
    localparam logic [3:0] HIGH_LAST = 4'(M2_HIGH_TICKS - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [1:0] next_state;
    logic [3:0] next_cnt;
    logic       start_cycle;
    logic       rise;
    logic       handshake;

    // Attributes of the bus cycle currently in flight.
    logic       cyc_a15;
    logic       cyc_rw;
    logic       cyc_idle;
    logic [7:0] cyc_wdata;

    // Next-phase and counter computation; the counter reloads on every phase change.
    always_comb begin
        next_state = ST_LOW;
        next_cnt   = LOW_LAST;
        case (state)
            ST_RST: begin
                next_state = ST_LOW;
                next_cnt   = LOW_LAST;
            end
            ST_LOW: begin
                if (cnt == 4'd0) begin
                    next_state = ST_HIGH;
                    next_cnt   = HIGH_LAST;
                end else begin
                    next_state = ST_LOW;
                    next_cnt   = cnt - 4'd1;
                end
            end
            ST_HIGH: begin
                if (cnt == 4'd0) begin
                    next_state = ST_LOW;
                    next_cnt   = LOW_LAST;
                end else begin
                    next_state = ST_HIGH;
                    next_cnt   = cnt - 4'd1;
                end
            end
            default: begin
                next_state = ST_LOW;
                next_cnt   = LOW_LAST;
            end
        endcase
    end

    // A new cycle begins at the end of the last HIGH tick (or leaving reset);
    // M2 rises at the end of the last LOW tick.
    assign start_cycle = (state == ST_RST) || ((state == ST_HIGH) && (cnt == 4'd0));
    assign rise        = (state == ST_LOW) && (cnt == 4'd0);
    assign handshake   = req_valid && req_ready;

    // Phase sequencing, cycle loading and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RST;
            cnt          <= 4'd0;
            cyc_a15      <= IDLE_ADDR[15];
            cyc_rw       <= 1'b1;
            cyc_idle     <= 1'b1;
            cyc_wdata    <= 8'h00;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            m2           <= 1'b0;
            romsel       <= 1'b1;
            cpu_rw       <= 1'b1;
            cpu_addr     <= IDLE_ADDR[14:0];
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            // Ready is presented during the last HIGH tick so the handshake
            // coincides with the edge that starts the next cycle.
            req_ready <= (next_state == ST_HIGH) && (next_cnt == 4'd0);
            rsp_valid <= 1'b0;

            if (start_cycle) begin
                // Read data is captured on the falling M2 edge of real reads.
                if ((state == ST_HIGH) && cyc_rw && !cyc_idle) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cpu_data_in;
                end
                m2          <= 1'b0;
                romsel      <= 1'b1;
                cpu_data_oe <= 1'b0;
                if (handshake) begin
                    cyc_a15   <= req_addr[15];
                    cyc_rw    <= req_rw;
                    cyc_idle  <= 1'b0;
                    cyc_wdata <= req_wdata;
                    cpu_addr  <= req_addr[14:0];
                    cpu_rw    <= req_rw;
                end else begin
                    cyc_a15   <= IDLE_ADDR[15];
                    cyc_rw    <= 1'b1;
                    cyc_idle  <= 1'b1;
                    cpu_addr  <= IDLE_ADDR[14:0];
                    cpu_rw    <= 1'b1;
                end
            end else if (rise) begin
                // /ROMSEL only ever changes together with M2, so it cannot
                // fall while M2 is low.
                m2          <= 1'b1;
                romsel      <= ~cyc_a15;
                cpu_data_oe <= ~cyc_rw;
                if (!cyc_rw) begin
                    cpu_data_out <= cyc_wdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_master
// Description : Self-checking bench for cpu_bus_master. A tick-indexed model
//               derives every output from the cycle position and the
//               requests accepted; a second instance runs single-tick phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_master;

    localparam int L = 3;
    localparam int H = 3;
    localparam int P = L + H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (3/3)
    logic        req_valid = 1'b0;
    logic        req_rw    = 1'b1;
    logic [15:0] req_addr  = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        req_ready, rsp_valid, m2, romsel, cpu_rw, cpu_data_oe;
    logic [7:0]  rsp_rdata, cpu_data_out;
    logic [14:0] cpu_addr;

    cpu_bus_master #(.M2_LOW_TICKS(L), .M2_HIGH_TICKS(H), .IDLE_ADDR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe),
        .cpu_data_in(cpu_data_in)
    );

    // Fast instance (1/1) with continuous reads of 0xC123
    logic        req_valid2 = 1'b1;
    logic        req_rw2    = 1'b1;
    logic [15:0] req_addr2  = 16'hC123;
    logic [7:0]  req_wdata2 = 8'h00;
    logic [7:0]  cpu_data_in2 = 8'h00;
    logic        req_ready2, rsp_valid2, m2_2, romsel2, cpu_rw2, cpu_data_oe2;
    logic [7:0]  rsp_rdata2, cpu_data_out2;
    logic [14:0] cpu_addr2;

    cpu_bus_master #(.M2_LOW_TICKS(1), .M2_HIGH_TICKS(1), .IDLE_ADDR(16'h0000)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_rw(req_rw2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .m2(m2_2), .romsel(romsel2), .cpu_rw(cpu_rw2), .cpu_addr(cpu_addr2),
        .cpu_data_out(cpu_data_out2), .cpu_data_oe(cpu_data_oe2),
        .cpu_data_in(cpu_data_in2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    int          mk;                 // ticks since reset release
    logic        m_rw, m_idle, m_rsp_pend;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rsp_data, m_last_rdata;

    // Observation counters used by the literal expectations
    int          rsp_cnt = 0;
    int          romsel_low_ticks = 0;
    int          oe_ticks = 0;
    logic [7:0]  last_oe_data = 8'h00;
    logic [14:0] last_oe_addr = 15'h0;
    logic        last_oe_rw = 1'b1;
    logic [7:0]  rsp_log[$];

    logic        din_hold = 1'b0;
    logic [7:0]  din_fixed = 8'h00;

    always @(negedge clk) begin
        int  p;
        logic e_m2;
        if (!rst_n) begin
            chk("rst_m2", m2, 0);
            chk("rst_romsel", romsel, 1);
            chk("rst_cpu_rw", cpu_rw, 1);
            chk("rst_cpu_addr", cpu_addr, 0);
            chk("rst_oe", cpu_data_oe, 0);
            chk("rst_data_out", cpu_data_out, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            mk = 0; m_rw = 1'b1; m_idle = 1'b1; m_addr = 16'h0000;
            m_wdata = 8'h00; m_rsp_pend = 1'b0; m_rsp_data = 8'h00; m_last_rdata = 8'h00;
        end else begin
            p    = mk % P;
            e_m2 = (p >= L);
            chk("m2", m2, e_m2);
            chk("romsel", romsel, !(e_m2 && m_addr[15]));
            chk("cpu_rw", cpu_rw, m_rw);
            chk("cpu_addr", cpu_addr, m_addr[14:0]);
            chk("oe", cpu_data_oe, e_m2 && !m_rw);
            if (e_m2 && !m_rw) chk("data_out", cpu_data_out, m_wdata);
            chk("req_ready", req_ready, p == P - 1);
            chk("rsp_valid", rsp_valid, (p == 0) && m_rsp_pend);
            if (p == 0 && m_rsp_pend) m_last_rdata = m_rsp_data;
            chk("rsp_rdata", rsp_rdata, m_last_rdata);
            chk("romsel_implies_m2", (!romsel) && (!m2), 0);

            if (rsp_valid) begin rsp_cnt++; rsp_log.push_back(rsp_rdata); end
            if (!romsel) romsel_low_ticks++;
            if (cpu_data_oe) begin
                oe_ticks++; last_oe_data = cpu_data_out;
                last_oe_addr = cpu_addr; last_oe_rw = cpu_rw;
            end

            if (p == 0) m_rsp_pend = 1'b0;
            if (p == P - 1) begin
                m_rsp_pend = m_rw && !m_idle;
                m_rsp_data = cpu_data_in;
                if (req_valid) begin
                    m_rw = req_rw; m_addr = req_addr; m_wdata = req_wdata; m_idle = 1'b0;
                end else begin
                    m_rw = 1'b1; m_addr = 16'h0000; m_idle = 1'b1;
                end
            end
            mk++;
        end
    end

    // ---------------- checker for the single-tick-phase instance ----------------
    int         k2 = 0;
    logic [7:0] prev_din2 = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            k2 = 0;
            chk("fast_rst_m2", m2_2, 0);
            chk("fast_rst_rsp", rsp_valid2, 0);
        end else begin
            chk("fast_m2", m2_2, (k2 % 2) == 1);
            chk("fast_addr", cpu_addr2, (k2 < 2) ? 15'h0000 : 15'h4123);
            chk("fast_romsel", romsel2, !(((k2 % 2) == 1) && k2 >= 2));
            chk("fast_rsp_valid", rsp_valid2, (k2 >= 4) && ((k2 % 2) == 0));
            if ((k2 >= 4) && ((k2 % 2) == 0)) chk("fast_rdata", rsp_rdata2, prev_din2);
            chk("fast_romsel_implies_m2", (!romsel2) && (!m2_2), 0);
            k2++;
        end
        prev_din2 = cpu_data_in2;
    end

    // Read data buses change shortly after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cpu_data_in  = din_hold ? din_fixed : 8'($urandom);
            cpu_data_in2 = 8'($urandom);
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d);
        int   n;
        logic hs;
        n = 0; hs = 1'b0;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = req_ready;
            n++;
            @(posedge clk);
            #1;
        end
        chk("handshake", hs, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        int r0;
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle: no responses, romsel never asserted
        r0 = rsp_cnt;
        ticks(100);
        chk("idle_rsp_count", rsp_cnt - r0, 0);
        chk("idle_romsel_low", romsel_low_ticks, 0);

        // Read 0x8000 returning 0xA5
        din_hold = 1'b1; din_fixed = 8'hA5;
        romsel_low_ticks = 0; rsp_log.delete();
        send(1'b1, 16'h8000, 8'h00);
        ticks(12);
        chk("read_romsel_low_ticks", romsel_low_ticks, 3);
        chk("read_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() > 0) chk("read_rdata", rsp_log[0], 8'hA5);
        din_hold = 1'b0;

        // Write 0xE000 <= 0x3C
        romsel_low_ticks = 0; oe_ticks = 0; r0 = rsp_cnt;
        send(1'b0, 16'hE000, 8'h3C);
        ticks(12);
        chk("write_oe_ticks", oe_ticks, 3);
        chk("write_data", last_oe_data, 8'h3C);
        chk("write_addr", last_oe_addr, 15'h6000);
        chk("write_rw", last_oe_rw, 0);
        chk("write_romsel_low_ticks", romsel_low_ticks, 3);
        chk("write_rsp_count", rsp_cnt - r0, 0);

        // Back-to-back: read 0x6000, write 0x8001, read 0xC000
        romsel_low_ticks = 0; rsp_log.delete();
        send(1'b1, 16'h6000, 8'h00);
        send(1'b0, 16'h8001, 8'h07);
        send(1'b1, 16'hC000, 8'h00);
        ticks(12);
        chk("b2b_rsp_count", rsp_log.size(), 2);
        chk("b2b_romsel_low_ticks", romsel_low_ticks, 6);

        // Randomized traffic with random gaps
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom), 16'($urandom), 8'($urandom));
            ticks($urandom_range(0, 8));
        end
        ticks(12);

        // Reset in the middle of a write's HIGH phase
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h8000; req_wdata = 8'h55;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 20);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_data_oe && n < 20);
        chk("mid_write_oe_seen", cpu_data_oe, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m2", m2, 0);
        chk("async_rst_romsel", romsel, 1);
        chk("async_rst_oe", cpu_data_oe, 0);
        r0 = rsp_cnt;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ticks(20);
        chk("post_rst_no_rsp", rsp_cnt - r0, 0);

        // Next request after reset completes normally
        rsp_log.delete();
        send(1'b1, 16'h8123, 8'h00);
        ticks(12);
        chk("post_rst_read_rsp", rsp_log.size(), 1);

        ticks(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
